instruction_sequencer: RTL and testbench

- Program store and fetch sequencer that sits directly upstream of tensor_core_controller.
- It drives current_instruction one word per clock from an on-chip instruction memory.
- The memory is loaded over a simple write port, then run from a start address until a HALT word.
- Honours a stall from the controller and never presents the same instruction twice, so a multi-cycle operation is never re-issued.

---
 rtl/instruction_sequencer.sv | 133 +++++++++++++
 tb/tb_instruction_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Program store and fetch sequencer feeding the tensor core controller.
// Issues one instruction word per clock from an internal memory until a HALT word.
module instruction_sequencer #(
    parameter int                     INSTR_WIDTH      = 16,
    parameter int                     ADDR_WIDTH       = 8,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION  = 16'h0000,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTRUCTION = 16'hFFFF,
    parameter int                     COUNT_WIDTH      = 16
) (
    input  logic                   clock_in,
    input  logic                   power_on_reset_signal_n,
    input  logic                   load_valid,
    input  logic [ADDR_WIDTH-1:0]  load_address,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic                   load_rejected,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_address,
    input  logic                   abort,
    input  logic                   stall_in,
    output logic [INSTR_WIDTH-1:0] current_instruction,
    output logic                   instruction_valid,
    output logic [ADDR_WIDTH-1:0]  program_counter,
    output logic                   running,
    output logic                   done,
    output logic                   overrun_error,
    output logic [COUNT_WIDTH-1:0] issued_count
);

    // state | meaning
    // IDLE  | waiting for start, memory writable
    // PRIME | first read of the program in flight
    // RUN   | issuing fetched words, honouring stall
    // DONE  | HALT reached or address space overrun, memory writable
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                 state;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] fetched_word;
    logic [ADDR_WIDTH-1:0]  fetched_addr;
    logic [ADDR_WIDTH-1:0]  ptr;
    logic                   wrapped;
    logic                   busy;
    logic                   write_en;
    logic                   read_en;
    logic                   issue;

    assign busy     = (state == PRIME) || (state == RUN);
    assign running  = busy;
    assign done     = (state == DONE);
    assign write_en = load_valid && !busy;

    always_comb begin
        issue = 1'b0;
        if (state == RUN && !abort && !stall_in &&
            fetched_word != HALT_INSTRUCTION && !wrapped)
            issue = 1'b1;
    end

    assign read_en = (!abort && state == PRIME) || issue;

    // fetched_word doubles as the one-entry prefetch register: it only
    // reloads when its current contents are consumed.
    always_ff @(posedge clock_in) begin
        if (write_en)
            mem[load_address] <= load_data;
        if (read_en)
            fetched_word <= mem[ptr];
    end

    always_ff @(posedge clock_in or negedge power_on_reset_signal_n) begin
        if (!power_on_reset_signal_n) begin
            state               <= IDLE;
            current_instruction <= NOP_INSTRUCTION;
            instruction_valid   <= 1'b0;
            program_counter     <= '0;
            overrun_error       <= 1'b0;
            issued_count        <= '0;
            load_rejected       <= 1'b0;
            ptr                 <= '0;
            fetched_addr        <= '0;
            wrapped             <= 1'b0;
        end else begin
            load_rejected       <= load_valid && busy;
            current_instruction <= NOP_INSTRUCTION;
            instruction_valid   <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                wrapped <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            ptr           <= start_address;
                            issued_count  <= '0;
                            overrun_error <= 1'b0;
                            wrapped       <= 1'b0;
                            state         <= PRIME;
                        end
                    end
                    PRIME: begin
                        fetched_addr <= ptr;
                        ptr          <= ptr + ADDR_WIDTH'(1);
                        state        <= RUN;
                    end
                    RUN: begin
                        if (!stall_in) begin
                            if (fetched_word == HALT_INSTRUCTION) begin
                                state <= DONE;
                            end else if (wrapped) begin
                                // word fetched from address 0 after the wrap is dropped
                                overrun_error <= 1'b1;
                                state         <= DONE;
                            end else begin
                                current_instruction <= fetched_word;
                                instruction_valid   <= 1'b1;
                                program_counter     <= fetched_addr;
                                if (issued_count != {COUNT_WIDTH{1'b1}})
                                    issued_count <= issued_count + COUNT_WIDTH'(1);
                                fetched_addr <= ptr;
                                ptr          <= ptr + ADDR_WIDTH'(1);
                                wrapped      <= (fetched_addr == {ADDR_WIDTH{1'b1}});
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer: fetch, stall,
// wrap overrun, abort, rejected loads and asynchronous reset.
module tb_instruction_sequencer;

    logic        clock_in = 1'b0;
    logic        power_on_reset_signal_n;
    logic        load_valid;
    logic [7:0]  load_address;
    logic [15:0] load_data;
    logic        load_rejected;
    logic        start;
    logic [7:0]  start_address;
    logic        abort;
    logic        stall_in;
    logic [15:0] current_instruction;
    logic        instruction_valid;
    logic [7:0]  program_counter;
    logic        running;
    logic        done;
    logic        overrun_error;
    logic [15:0] issued_count;

    int tests_run = 0;
    int tests_failed = 0;

    instruction_sequencer dut (
        .clock_in               (clock_in),
        .power_on_reset_signal_n(power_on_reset_signal_n),
        .load_valid             (load_valid),
        .load_address           (load_address),
        .load_data              (load_data),
        .load_rejected          (load_rejected),
        .start                  (start),
        .start_address          (start_address),
        .abort                  (abort),
        .stall_in               (stall_in),
        .current_instruction    (current_instruction),
        .instruction_valid      (instruction_valid),
        .program_counter        (program_counter),
        .running                (running),
        .done                   (done),
        .overrun_error          (overrun_error),
        .issued_count           (issued_count)
    );

    always #5 clock_in = ~clock_in;

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_issue(input string tag, input logic [15:0] instr, input logic [7:0] pc,
                               input logic [15:0] cnt);
        check({tag, ".instr"}, current_instruction, instr);
        check({tag, ".valid"}, instruction_valid, 1);
        check({tag, ".pc"}, program_counter, pc);
        check({tag, ".count"}, issued_count, cnt);
    endtask

    task automatic check_nop(input string tag);
        check({tag, ".instr"}, current_instruction, 16'h0000);
        check({tag, ".valid"}, instruction_valid, 0);
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] data);
        load_valid   = 1'b1;
        load_address = addr;
        load_data    = data;
        step();
        load_valid   = 1'b0;
    endtask

    task automatic kick(input logic [7:0] addr);
        start         = 1'b1;
        start_address = addr;
        step();
        start         = 1'b0;
    endtask

    initial begin
        power_on_reset_signal_n = 1'b0;
        load_valid = 1'b0; load_address = '0; load_data = '0;
        start = 1'b0; start_address = '0; abort = 1'b0; stall_in = 1'b0;
        step(); step();
        check_nop("reset");
        check("reset.pc", program_counter, 0);
        check("reset.running", running, 0);
        check("reset.done", done, 0);
        check("reset.overrun", overrun_error, 0);
        check("reset.count", issued_count, 0);
        check("reset.rej", load_rejected, 0);
        power_on_reset_signal_n = 1'b1;
        step();

        load(8'd0, 16'h1234);
        load(8'd1, 16'h2345);
        load(8'd2, 16'h3456);
        load(8'd3, 16'hFFFF);
        load(8'd254, 16'hAAAA);
        load(8'd255, 16'hBBBB);
        check("idle_load.rej", load_rejected, 0);

        // basic run: first word after edge t+2
        kick(8'd0);
        check("run.prime_running", running, 1);
        check_nop("run.prime");
        step(); check_nop("run.t1");
        step(); check_issue("run.w0", 16'h1234, 8'd0, 16'd1);
        step(); check_issue("run.w1", 16'h2345, 8'd1, 16'd2);
        step(); check_issue("run.w2", 16'h3456, 8'd2, 16'd3);
        step(); check_nop("run.halt");
        check("run.done", done, 1);
        check("run.running", running, 0);
        check("run.count_final", issued_count, 3);

        // stall for 3 cycles when 0x2345 is due
        kick(8'd0);
        step();
        step(); check_issue("stall.w0", 16'h1234, 8'd0, 16'd1);
        stall_in = 1'b1;
        step(); check_nop("stall.s0");
        step(); check_nop("stall.s1");
        step(); check_nop("stall.s2");
        check("stall.count_held", issued_count, 1);
        stall_in = 1'b0;
        step(); check_issue("stall.w1", 16'h2345, 8'd1, 16'd2);
        step(); check_issue("stall.w2", 16'h3456, 8'd2, 16'd3);
        step(); check_nop("stall.halt");
        check("stall.done", done, 1);
        check("stall.count_final", issued_count, 3);

        // wrap past the top of memory without HALT
        kick(8'd254);
        step();
        step(); check_issue("wrap.w254", 16'hAAAA, 8'd254, 16'd1);
        step(); check_issue("wrap.w255", 16'hBBBB, 8'd255, 16'd2);
        step(); check_nop("wrap.after");
        check("wrap.overrun", overrun_error, 1);
        check("wrap.done", done, 1);
        check("wrap.count", issued_count, 2);
        step(); check_nop("wrap.after2");
        check("wrap.overrun_sticky", overrun_error, 1);

        // abort after first valid word, then restart
        kick(8'd0);
        check("abort.overrun_cleared", overrun_error, 0);
        step();
        step(); check_issue("abort.w0", 16'h1234, 8'd0, 16'd1);
        abort = 1'b1;
        step(); abort = 1'b0;
        check_nop("abort.out");
        check("abort.running", running, 0);
        check("abort.done", done, 0);
        step(); check_nop("abort.idle");
        kick(8'd0);
        step();
        step(); check_issue("restart.w0", 16'h1234, 8'd0, 16'd1);
        step(); step(); step();
        check("restart.done", done, 1);

        // load during RUN is rejected
        kick(8'd0);
        step();
        load_valid = 1'b1; load_address = 8'd1; load_data = 16'h7777;
        step(); load_valid = 1'b0;
        check("rej.pulse", load_rejected, 1);
        check_issue("rej.w0", 16'h1234, 8'd0, 16'd1);
        step();
        check("rej.pulse_end", load_rejected, 0);
        check_issue("rej.w1", 16'h2345, 8'd1, 16'd2);
        step(); step();
        check("rej.done", done, 1);
        kick(8'd0);
        step(); step();
        step(); check_issue("rerun.w1", 16'h2345, 8'd1, 16'd2);

        // asynchronous reset between edges while running
        #2;
        power_on_reset_signal_n = 1'b0;
        #1;
        check_nop("areset");
        check("areset.running", running, 0);
        check("areset.count", issued_count, 0);
        check("areset.pc", program_counter, 0);
        step();
        power_on_reset_signal_n = 1'b1;
        step();
        kick(8'd0);
        step();
        step(); check_issue("post_reset.w0", 16'h1234, 8'd0, 16'd1);
        step(); check_issue("post_reset.w1", 16'h2345, 8'd1, 16'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
